// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the byte-addressed instruction/data memory pipe.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package inst_mem_pkg;

  localparam int RD_LAT_MAX = 4;
  // Widest word any instance may use; narrower instances leave the upper rdata bits zero.
  localparam int DATA_W_MAX = 512;

  typedef struct packed {
    logic                  err;
    logic [DATA_W_MAX-1:0] rdata;
  } rsp_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/inst_mem_rsp_pipe.sv
// Fixed-depth valid/data delay line carrying responses; the last stage drives the output.
// Latency: DEPTH cycles from in_vld to out_vld when not stalled.
// Backpressure: stall freezes every stage, including bubbles, so stage data stays stable.
module inst_mem_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (!stall) begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/inst_mem_pipe.sv
// Big-endian byte-array memory with byte-enable writes; INST_MEM_PIPE_ALIGN_CHECK_EN rejects misaligned accesses.
// Latency: every request answered RD_LAT cycles after acceptance, plus any stall cycles.
// Backpressure: rsp_valid & ~rsp_ready stalls the whole pipe and drops req_ready.
module inst_mem_pipe
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [DATA_W/8-1:0]        req_be,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int DEPTH = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam int RSP_W = $bits(rsp_t);

  logic              stall;
  logic              accept;
  logic              rdy_q;
  logic              misalign;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] byte_addr [BPW];
  logic [BPW-1:0]    byte_we;
  logic [DATA_W-1:0] rd_word;
  rsp_t              rsp_in;
  rsp_t              rsp_out;
  logic              unused_rsp;
  logic [7:0]        mem [2**ADDR_W];

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = rdy_q & ~stall;
  assign accept    = req_valid & req_ready;

  // Holds req_ready low through reset and releases it on the first clock after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

`ifdef INST_MEM_PIPE_ALIGN_CHECK_EN
  assign misalign  = (req_addr & ADDR_W'(BPW - 1)) != '0;
  assign word_addr = req_addr;
`else
  assign misalign  = 1'b0;
  assign word_addr = req_addr & ~ADDR_W'(BPW - 1);
`endif

  // Byte k of the word sits at addr+k (wrapping) and maps to the k-th byte from the MSB.
  always_comb begin
    byte_addr = '{default: '0};
    byte_we   = '0;
    rd_word   = '0;
    for (int k = 0; k < BPW; k++) begin
      byte_addr[k]               = word_addr + ADDR_W'(k);
      byte_we[k]                 = accept & req_we & ~misalign & req_be[BPW-1-k];
      rd_word[DATA_W-1-8*k -: 8] = mem[word_addr + ADDR_W'(k)];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BPW; k++) begin
      if (byte_we[k]) mem[byte_addr[k]] <= req_wdata[DATA_W-1-8*k -: 8];
    end
  end

  always_comb begin
    rsp_in = '0;
    if (accept) begin
      rsp_in.err = misalign;
      if (!req_we && !misalign) rsp_in.rdata[DATA_W-1:0] = rd_word;
    end
  end

  inst_mem_rsp_pipe #(
    .DEPTH (DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_pipe (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .in_vld  (accept),
    .in_dat  (rsp_in),
    .out_vld (rsp_valid),
    .out_dat (rsp_out)
  );

  assign rsp_rdata  = rsp_out.rdata[DATA_W-1:0];
  assign unused_rsp = ^rsp_out;

`ifdef INST_MEM_PIPE_ALIGN_CHECK_EN
  assign rsp_err = rsp_out.err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Randomised and directed bench for inst_mem_pipe against a byte-array reference and response queue.
// Latency: checks RD_LAT exactly for responses that saw no stall.
// Backpressure: drives rsp_ready low in bursts and randomly; checks req_ready and held outputs.
module tb_inst_mem_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  inst_mem_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc_edge;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [4096];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rst_rel_edge = 1 << 30;
  int          last_stall_edge = -1;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err = 1'b0;
  int          hold_low = 0;
  bit          rand_ready = 1'b0;
  bit          count_low = 1'b0;
  int          low_cnt = 0;
  int          rsp_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: requests applied in acceptance order to a flat big-endian byte array.
  function automatic void model_accept(input logic we, input logic [3:0] be,
                                       input logic [11:0] addr, input logic [31:0] wdata,
                                       input int edge_no);
    exp_t        e;
    int          a;
    logic [31:0] r;
    e.acc_edge = edge_no;
    e.err      = 1'b0;
    e.rdata    = '0;
    a          = int'(addr);
`ifdef INST_MEM_PIPE_ALIGN_CHECK_EN
    if (a % 4 != 0) begin
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
`else
    a = a - (a % 4);
`endif
    r = '0;
    for (int k = 0; k < 4; k++) r = (r << 8) | 32'(ref_mem[(a + k) % 4096]);
    if (!we) e.rdata = r;
    else begin
      for (int k = 0; k < 4; k++)
        if (be[3-k]) ref_mem[(a + k) % 4096] = wdata[31-8*k -: 8];
    end
    exp_q.push_back(e);
  endfunction

  // One cycle, entered at a negedge with request inputs already set.
  task automatic step(output bit acc);
    exp_t e;
    bit   stalled;
    int   up;
    if (hold_low > 0) begin
      rsp_ready = 1'b0;
      hold_low--;
    end else if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    else rsp_ready = 1'b1;
    #1;
    up      = edge_cnt + 1;
    stalled = rsp_valid && !rsp_ready;
    if (stalled) last_stall_edge = up;
    if (edge_cnt > rst_rel_edge) check_eq("req_ready", 64'(req_ready), 64'(!stalled));
    if (prev_stalled) begin
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(prev_rdata));
      check_eq("hold_err", 64'(rsp_err), 64'(prev_err));
    end
    if (exp_q.size() == 0) check_eq("spurious_rsp", 64'(rsp_valid), 64'd0);
    else if (rsp_valid && rsp_ready) begin
      e = exp_q.pop_front();
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
      if (e.acc_edge > last_stall_edge) check_eq("latency", 64'(up - e.acc_edge), 64'(RD_LAT));
      rsp_cnt++;
    end
    if (count_low && !req_ready) low_cnt++;
    acc = req_valid && req_ready;
    if (acc) model_accept(req_we, req_be, req_addr, req_wdata, up);
    prev_stalled = stalled;
    prev_rdata   = rsp_rdata;
    prev_err     = rsp_err;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [11:0] addr,
                       input logic [31:0] wdata);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    if (!acc) check_eq("accept_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit unused_acc;
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_be    = 4'($urandom);
      req_addr  = 12'($urandom);
      req_wdata = $urandom;
      step(unused_acc);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    rst_rel_edge = edge_cnt;

    for (int a = 0; a < 256; a += 4) issue(1'b1, 4'hF, 12'(a), $urandom);
    for (int a = 12'hFF0; a < 4096; a += 4) issue(1'b1, 4'hF, 12'(a), $urandom);
    drain();

    issue(1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
    check_eq("mem_byte_010", 64'(dut.mem[16]), 64'hDE);
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    drain();

    issue(1'b1, 4'hF, 12'h020, 32'hAABBCCDD);
    issue(1'b1, 4'b0101, 12'h020, 32'h11223344);
    issue(1'b0, 4'hF, 12'h020, 32'h0);
    drain();
    check_eq("mem_byte_021", 64'(dut.mem[33]), 64'h22);
    check_eq("mem_byte_022", 64'(dut.mem[34]), 64'hCC);

    issue(1'b1, 4'hF, 12'hFFC, 32'h01020304);
    issue(1'b0, 4'hF, 12'hFFC, 32'h0);
`ifndef INST_MEM_PIPE_ALIGN_CHECK_EN
    issue(1'b0, 4'hF, 12'hFFE, 32'h0);
`endif
    drain();

`ifdef INST_MEM_PIPE_ALIGN_CHECK_EN
    issue(1'b0, 4'hF, 12'h013, 32'h0);
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    issue(1'b1, 4'hF, 12'h012, 32'hFFFFFFFF);
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    drain();
`endif

    // Four back-to-back reads with a three-cycle consumer stall once the first response is up.
    rsp_cnt = 0;
    low_cnt = 0;
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    issue(1'b0, 4'hF, 12'h020, 32'h0);
    hold_low  = 3;
    count_low = 1'b1;
    issue(1'b0, 4'hF, 12'hFFC, 32'h0);
    issue(1'b0, 4'hF, 12'h000, 32'h0);
    count_low = 1'b0;
    drain();
    check_eq("stall_ready_low", 64'(low_cnt), 64'd3);
    check_eq("stall_rsp_count", 64'(rsp_cnt), 64'd4);

    // Reset with two reads in flight: outputs drop asynchronously, memory survives.
    hold_low = 20;
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    issue(1'b0, 4'hF, 12'h020, 32'h0);
    check_eq("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("async_req_ready", 64'(req_ready), 64'd0);
    check_eq("async_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("async_rsp_err", 64'(rsp_err), 64'd0);
    exp_q.delete();
    hold_low     = 0;
    prev_stalled = 1'b0;
    rst_rel_edge = 1 << 30;
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    rst_rel_edge = edge_cnt;
    idle(6);
    issue(1'b0, 4'hF, 12'h010, 32'h0);
    issue(1'b0, 4'hF, 12'h020, 32'h0);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else issue(1'($urandom), 4'($urandom),
                 ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 255))
                                             : 12'(12'hFF0 + $urandom_range(0, 15)),
                 $urandom);
    end
    rand_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
